// File: rtl/alu_pkg.sv
// Shared opcode and controller-state definitions for the ALU sharing controller.
package alu_pkg;

   localparam logic [2:0] OP_CLR  = 3'd0;
   localparam logic [2:0] OP_PASS = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_MUL  = 3'd4;
   localparam logic [2:0] OP_INC  = 3'd5;
   localparam logic [2:0] OP_IDLE = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // idle and reserved opcodes never produce a meaningful ALU result
   function automatic logic op_yields_zero(input logic [2:0] op);
      return (op == OP_IDLE) || (op == OP_RSVD);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or after ptr.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          any
);

   int            w_idx;
   logic [PW-1:0] w_sel;

   // scan from ptr with wrap-around, first hit wins
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      w_idx   = 0;
      w_sel   = '0;
      for (int k = 0; k < N; k++) begin
         w_idx = int'(ptr) + k;
         if (w_idx >= N) begin
            w_idx = w_idx - N;
         end else begin
            w_idx = w_idx;
         end
         w_sel = PW'(w_idx);
         if (!any && req[w_sel]) begin
            any        = 1'b1;
            gnt[w_sel] = 1'b1;
            gnt_idx    = w_sel;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between N_REQ requesters with round-robin
// arbitration, registered ALU drive and a one-cycle response strobe.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH   = 12,
   parameter int N_REQ   = 4,
   parameter int MUL_LAT = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ*3-1:0]     req_op,
   output logic [N_REQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]       resp_data,
   output logic                   busy,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic [2:0]             alu_selectOp,
   input  logic [WIDTH-1:0]       alu_dataOut
);

   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = 3;

   state_e           r_state;
   state_e           w_next_state;
   logic [GW-1:0]    r_rr_ptr;
   logic [GW-1:0]    r_gnt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [2:0]       r_alu_op;
   logic [N_REQ-1:0] r_resp_valid;
   logic [WIDTH-1:0] r_resp_data;

   logic [N_REQ-1:0] w_arb_gnt;
   logic [GW-1:0]    w_arb_idx;
   logic             w_arb_any;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic [2:0]       w_sel_op;
   logic             w_exec_last;

   rr_arbiter #(
      .N  (N_REQ),
      .PW (GW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (r_rr_ptr),
      .gnt     (w_arb_gnt),
      .gnt_idx (w_arb_idx),
      .any     (w_arb_any)
   );

   assign w_exec_last = (r_cnt == CW'(0));

   // operand/opcode mux for the requester the arbiter currently selects
   always_comb begin
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_sel_op = OP_IDLE;
      for (int i = 0; i < N_REQ; i++) begin
         if (GW'(i) == w_arb_idx) begin
            w_sel_a  = req_a[i*WIDTH +: WIDTH];
            w_sel_b  = req_b[i*WIDTH +: WIDTH];
            w_sel_op = req_op[i*3 +: 3];
         end else begin
            w_sel_op = w_sel_op;
         end
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next-state logic
   always_comb begin
      w_next_state = ST_IDLE;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_any) begin
               w_next_state = ST_EXEC;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (w_exec_last) begin
               w_next_state = ST_RESP;
            end else begin
               w_next_state = ST_EXEC;
            end
         end
         ST_RESP: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // grant and busy outputs; grants are only offered while idle
   always_comb begin
      req_ready = '0;
      busy      = 1'b0;
      if (r_state == ST_IDLE) begin
         req_ready = w_arb_gnt;
         busy      = 1'b0;
      end else begin
         req_ready = '0;
         busy      = 1'b1;
      end
   end

   // datapath: latch at grant, capture on last EXEC cycle, release in RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr     <= '0;
         r_gnt        <= '0;
         r_cnt        <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= OP_IDLE;
         r_resp_valid <= '0;
         r_resp_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_resp_valid <= '0;
               if (w_arb_any) begin
                  r_gnt    <= w_arb_idx;
                  r_alu_a  <= w_sel_a;
                  r_alu_b  <= w_sel_b;
                  r_alu_op <= w_sel_op;
                  r_cnt    <= (w_sel_op == OP_MUL) ? CW'(MUL_LAT - 1) : CW'(0);
               end else begin
                  r_gnt <= r_gnt;
               end
            end
            ST_EXEC: begin
               if (w_exec_last) begin
                  r_resp_data  <= op_yields_zero(r_alu_op) ? '0 : alu_dataOut;
                  r_resp_valid <= N_REQ'(1) << r_gnt;
                  r_alu_a      <= '0;
                  r_alu_b      <= '0;
                  r_alu_op     <= OP_IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            ST_RESP: begin
               r_resp_valid <= '0;
               r_rr_ptr     <= (r_gnt == GW'(N_REQ - 1)) ? GW'(0) : r_gnt + GW'(1);
            end
            default: begin
               r_resp_valid <= '0;
            end
         endcase
      end
   end

   assign alu_a        = r_alu_a;
   assign alu_b        = r_alu_b;
   assign alu_selectOp = r_alu_op;
   assign resp_valid   = r_resp_valid;
   assign resp_data    = r_resp_data;

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Time-shares the single combinational ALU (clr/pass/add/sub/mul/inc/idle, signed WIDTH-bit) between N_REQ core requesters in the multicore processor.
- Accepts one operation per transaction through a valid/ready handshake and selects requesters round-robin.
- Drives the ALU operand and opcode ports from registered values, and holds them for one cycle, or MUL_LAT cycles for mul.
- Captures the ALU result and returns it to the granted requester with a one-cycle resp_valid pulse.

Parameters:
- WIDTH, 12: ALU operand/result width, signed two's complement.
- N_REQ, 4: number of requesters (2..8).
- MUL_LAT, 2: cycles the ALU inputs are held for mul before capture (1..4).

Ports:
- clk, input, 1: system clock, rising-edge.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, N_REQ: per-requester operation request.
- req_ready, output, N_REQ: one-hot grant; handshake occurs when req_valid[i] and req_ready[i] are both high.
- req_a, input, N_REQ*WIDTH: operand a; slice i is [i*WIDTH +: WIDTH].
- req_b, input, N_REQ*WIDTH: operand b, packed the same way.
- req_op, input, N_REQ*3: opcode; slice i is [i*3 +: 3].
- resp_valid, output, N_REQ: one-hot, one-cycle result strobe.
- resp_data, output, WIDTH: result, shared by all requesters.
- busy, output, 1: high in EXEC and RESP.
- alu_a, output, WIDTH: to ALU a.
- alu_b, output, WIDTH: to ALU b.
- alu_selectOp, output, 3: to ALU selectOp.
- alu_dataOut, input, WIDTH: from ALU dataOut.

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_data=0, busy=0.
  - alu_a=0, alu_b=0, alu_selectOp=idle (3'd6).
- A reset asserted during EXEC or RESP aborts the transaction: no resp_valid is produced and the held result is lost.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational: one-hot on the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - If no requester is valid, req_ready=0 and the state stays IDLE.
  - On a handshake (cycle T), register gnt=i and latch a/b/op into alu_a/alu_b/alu_selectOp; next state EXEC.
- EXEC:
  - ALU inputs held stable; req_ready=0.
  - Non-mul ops last exactly 1 cycle. mul lasts MUL_LAT cycles, counted by a cycle counter loaded at grant.
  - On the last EXEC cycle: resp_data <= alu_dataOut, except op=idle or op=7 (reserved), which capture 0.
  - Next state RESP.
- RESP:
  - resp_valid[gnt]=1 for exactly one cycle; resp_data is valid in that cycle and is held until the next capture.
  - alu_selectOp returns to idle and alu_a/alu_b to 0.
  - rr_ptr <= (gnt+1) mod N_REQ; next state IDLE.
- Latency: non-mul resp_valid at cycle T+2; mul at T+1+MUL_LAT.
  - Minimum issue interval is 3 cycles; no new grant is made during EXEC or RESP.
- Arithmetic: the ALU defines results (truncated to WIDTH); the controller never widens or saturates.
- Requester obligations:
  - Hold req_valid and its operands stable until granted.
  - Dropping req_valid before a grant is legal and simply removes that requester from arbitration.
- Fairness: a requester continuously asserting req_valid is granted within N_REQ transactions.
- Wrap-around: rr_ptr at N_REQ-1 advances to 0.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants: CLR=0, PASS=1, ADD=2, SUB=3, MUL=4, INC=5, IDLE=6, RSVD=7.
  - State encodings: IDLE/EXEC/RESP.
- One sub-module, rr_arbiter: purely combinational.
  - Inputs: req[N_REQ], ptr.
  - Outputs: one-hot gnt, gnt_idx, any.
  - Reusable for other shared resources.

Test Plan:
- Reset state: hold rst for 2 cycles -> all outputs 0, alu_selectOp=6, busy=0. Apply rst in EXEC after a req0 grant -> no resp_valid follows, state IDLE.
- Single add: req0 valid, a=10, b=3, op=ADD at cycle T -> req_ready=4'b0001 at T, alu_selectOp=2 at T+1, resp_valid=4'b0001 with resp_data=13 at T+2.
- Mul latency: req1, a=20, b=-30, op=MUL, MUL_LAT=2 -> ALU inputs held for T+1..T+2, resp_valid[1] at T+3, resp_data=-600.
- Round-robin: all four requesters valid continuously, each sub 5-7 -> grant order 0,1,2,3,0; each resp_data=-2; grants 3 cycles apart.
- Wrap and skip: rr_ptr=3 with only req1 and req3 valid -> req3 granted first, then req1; rr_ptr ends at 2.
- Reserved/idle ops: op=7 or op=6 from req2 -> resp_valid[2] at T+2 with resp_data=0. Then inc with a=2047 -> resp_data=-2048 (wrap).
